// File: rtl/acc_bus_ctrl_if.sv
// acc_bus_ctrl_if: request/response channel between the datapath and
// the accumulator-store bus controller (master = datapath, slave = ctrl).
interface acc_bus_ctrl_if #(
  parameter int DATA_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [DATA_W-1:0] req_mask;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_rw, req_mask, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_rw, req_mask, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/acc_bus_ctrl.sv
// acc_bus_ctrl: bus initiator for the bit-addressed accumulator store.
// Turns a valid/ready request into a SETUP/ACCESS/RELEASE bus cycle.
// Ports: clock, reset (sync, active high); dp = request/response
// channel (slave side); bus_rw / bus_add / data_bus = store bus.
// Build option ACC_WR_VERIFY_EN: every write is followed by an
// automatic readback; rsp_rdata/rsp_err report the verify result.
module acc_bus_ctrl #(
  parameter int WAIT_CYC = 1,
  parameter int DATA_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  acc_bus_ctrl_if.slave     dp,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_add,
  inout  wire  [DATA_W-1:0] data_bus
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

`ifdef ACC_WR_VERIFY_EN
  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RELEASE,
    S_VSETUP,
    S_VACCESS,
    S_VRELEASE,
    S_VEVAL,
    S_RESP
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RELEASE,
    S_RESP
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_rw_q, bus_rw_d;
  logic [DATA_W-1:0] bus_add_q, bus_add_d;
  logic              bus_oe_q, bus_oe_d;
`ifdef ACC_WR_VERIFY_EN
  logic              err_q, err_d;
`endif

  // Next state and request/read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef ACC_WR_VERIFY_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (dp.req_valid) begin
          state_d = S_SETUP;
          rw_d    = dp.req_rw;
          mask_d  = dp.req_mask;
          wdata_d = dp.req_wdata;
          rdata_d = '0;
`ifdef ACC_WR_VERIFY_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = CNT_INIT;
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RELEASE;
          // Unenabled bits float on the bus; force them to 0.
          if (rw_q) rdata_d = data_bus & mask_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef ACC_WR_VERIFY_EN
      S_RELEASE: begin
        state_d = rw_q ? S_RESP : S_VSETUP;
      end
      S_VSETUP: begin
        state_d = S_VACCESS;
        cnt_d   = CNT_INIT;
      end
      S_VACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_VRELEASE;
          rdata_d = data_bus & mask_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_VRELEASE: begin
        state_d = S_VEVAL;
      end
      S_VEVAL: begin
        state_d = S_RESP;
        err_d   = |((rdata_q ^ wdata_q) & mask_q);
      end
`else
      S_RELEASE: begin
        state_d = S_RESP;
      end
`endif
      S_RESP: begin
        if (dp.rsp_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus pins are decoded from the upcoming state so that they
  // come straight from flops.
  always_comb begin
    bus_rw_d  = 1'b1;
    bus_add_d = '0;
    bus_oe_d  = 1'b0;
    unique case (state_d)
      S_SETUP: begin
        bus_rw_d = rw_d;
        bus_oe_d = !rw_d;
      end
      S_ACCESS: begin
        bus_rw_d  = rw_d;
        bus_add_d = mask_d;
        bus_oe_d  = !rw_d;
      end
`ifdef ACC_WR_VERIFY_EN
      S_VACCESS: begin
        bus_add_d = mask_d;
      end
`endif
      default: begin
        bus_rw_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rw_q      <= 1'b1;
      mask_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bus_rw_q  <= 1'b1;
      bus_add_q <= '0;
      bus_oe_q  <= 1'b0;
`ifdef ACC_WR_VERIFY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      mask_q    <= mask_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      bus_rw_q  <= bus_rw_d;
      bus_add_q <= bus_add_d;
      bus_oe_q  <= bus_oe_d;
`ifdef ACC_WR_VERIFY_EN
      err_q     <= err_d;
`endif
    end
  end

  assign bus_rw       = bus_rw_q;
  assign bus_add      = bus_add_q;
  assign data_bus     = bus_oe_q ? wdata_q : {DATA_W{1'bz}};

  assign dp.req_ready = (state_q == S_IDLE);
  assign dp.rsp_valid = (state_q == S_RESP);
  assign dp.rsp_rdata = rdata_q;
`ifdef ACC_WR_VERIFY_EN
  assign dp.rsp_err   = err_q;
`else
  assign dp.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_acc_bus_ctrl.sv
// tb_acc_bus_ctrl: directed bench for acc_bus_ctrl with a simple
// bit-addressed store model on the shared tri-state bus.
module tb_acc_bus_ctrl;

`ifdef ACC_WR_VERIFY_EN
  localparam bit VERIFY = 1'b1;
  localparam int WR_LAT = 7;
  localparam int WR_ACC = 2;
`else
  localparam bit VERIFY = 1'b0;
  localparam int WR_LAT = 3;
  localparam int WR_ACC = 1;
`endif

  logic       clock;
  logic       reset;
  logic       bus_rw, bus_rw3;
  logic [7:0] bus_add, bus_add3;
  wire  [7:0] data_bus, bus3;

  acc_bus_ctrl_if #(.DATA_W(8)) dp ();
  acc_bus_ctrl_if #(.DATA_W(8)) dp3 ();

  acc_bus_ctrl #(.WAIT_CYC(1), .DATA_W(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .dp       (dp),
    .bus_rw   (bus_rw),
    .bus_add  (bus_add),
    .data_bus (data_bus)
  );

  acc_bus_ctrl #(.WAIT_CYC(3), .DATA_W(8)) dut3 (
    .clock    (clock),
    .reset    (reset),
    .dp       (dp3),
    .bus_rw   (bus_rw3),
    .bus_add  (bus_add3),
    .data_bus (bus3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Store model: latches enabled bits on write edges, drives on reads.
  logic [7:0] mem;
  logic       stuck_b2;
  initial mem = 8'h00;
  always @(posedge clock)
    for (int i = 0; i < 8; i++)
      if (bus_add[i] && !bus_rw) mem[i] <= data_bus[i];
  assign data_bus = (bus_rw && bus_add != 8'h00)
                  ? (stuck_b2 ? (mem & 8'hFB) : mem) : 8'bz;
  assign bus3 = (bus_rw3 && bus_add3 != 8'h00) ? 8'h5A : 8'bz;

  int checks = 0;
  int errors = 0;
  logic [7:0] cur_mask;
  int add_tot = 0, bad_tot = 0, viol_tot = 0, add3_tot = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus_add != 8'h00) begin
        add_tot++;
        if (bus_add != cur_mask) bad_tot++;
      end
      if (dut.bus_oe_q && bus_rw) viol_tot++;
      if (bus_add3 != 8'h00) add3_tot++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic transact(input logic rw, input logic [7:0] mask,
                          input logic [7:0] wd, output logic [7:0] rd,
                          output logic er, output int lat,
                          output int acc, output int bad);
    int a0, b0;
    @(negedge clock);
    a0 = add_tot;
    b0 = bad_tot;
    cur_mask     = mask;
    dp.req_valid = 1'b1;
    dp.req_rw    = rw;
    dp.req_mask  = mask;
    dp.req_wdata = wd;
    @(posedge clock); #1;
    dp.req_valid = 1'b0;
    dp.req_mask  = 8'h00;
    dp.req_wdata = 8'h00;
    lat = 0;
    while (!dp.rsp_valid && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    rd = dp.rsp_rdata;
    er = dp.rsp_err;
    @(negedge clock);
    dp.rsp_ready = 1'b1;
    @(posedge clock); #1;
    dp.rsp_ready = 1'b0;
    acc = add_tot - a0;
    bad = bad_tot - b0;
  endtask

  logic [7:0] rd;
  logic       er;
  int lat, acc, bad, n, v0, a3;

  initial begin
    reset = 1'b1;
    stuck_b2 = 1'b0;
    cur_mask = 8'h00;
    dp.req_valid = 1'b0; dp.req_rw = 1'b1;
    dp.req_mask = 8'h00; dp.req_wdata = 8'h00; dp.rsp_ready = 1'b0;
    dp3.req_valid = 1'b0; dp3.req_rw = 1'b1;
    dp3.req_mask = 8'h00; dp3.req_wdata = 8'h00; dp3.rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_bus_add", int'(bus_add), 0);
    chk("rst_bus_rw", int'(bus_rw), 1);
    chk("rst_oe", int'(dut.bus_oe_q), 0);
    chk("rst_req_ready", int'(dp.req_ready), 1);
    chk("rst_rsp_valid", int'(dp.rsp_valid), 0);
    chk("rst_rsp_rdata", int'(dp.rsp_rdata), 0);
    chk("rst_rsp_err", int'(dp.rsp_err), 0);
    @(negedge clock);
    reset = 1'b0;

    // Reset asserted in the middle of a write access.
    @(negedge clock);
    dp.req_valid = 1'b1; dp.req_rw = 1'b0;
    dp.req_mask = 8'hFF; dp.req_wdata = 8'h00;
    @(posedge clock); #1;
    dp.req_valid = 1'b0;
    @(posedge clock); #1;
    chk("mid_in_access", int'(bus_add), 'hFF);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("mid_rst_add", int'(bus_add), 0);
    chk("mid_rst_oe", int'(dut.bus_oe_q), 0);
    chk("mid_rst_rw", int'(bus_rw), 1);
    chk("mid_rst_ready", int'(dp.req_ready), 1);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("mid_rst_no_rsp", int'(dp.rsp_valid), 0);

    // Full-mask write then read.
    transact(1'b0, 8'hFF, 8'hA5, rd, er, lat, acc, bad);
    chk("wr_a5_rdata", int'(rd), VERIFY ? 'hA5 : 0);
    chk("wr_a5_err", int'(er), 0);
    chk("wr_a5_lat", lat, WR_LAT);
    chk("wr_a5_acc", acc, WR_ACC);
    chk("wr_a5_addmask", bad, 0);
    transact(1'b1, 8'hFF, 8'h00, rd, er, lat, acc, bad);
    chk("rd_a5_rdata", int'(rd), 'hA5);
    chk("rd_a5_lat", lat, 3);
    chk("rd_a5_acc", acc, 1);
    chk("rd_a5_addmask", bad, 0);

    // Partial write merges with stored bits.
    transact(1'b0, 8'h0F, 8'h3C, rd, er, lat, acc, bad);
    chk("wr_3c_rdata", int'(rd), VERIFY ? 'h0C : 0);
    chk("wr_3c_err", int'(er), 0);
    transact(1'b1, 8'hFF, 8'h00, rd, er, lat, acc, bad);
    chk("rd_ac", int'(rd), 'hAC);
    transact(1'b1, 8'hF0, 8'h00, rd, er, lat, acc, bad);
    chk("rd_f0", int'(rd), 'hA0);

    // Mask 0: sequence runs, nothing enabled, nothing written.
    transact(1'b1, 8'h00, 8'h00, rd, er, lat, acc, bad);
    chk("rd_m0_rdata", int'(rd), 0);
    chk("rd_m0_acc", acc, 0);
    chk("rd_m0_lat", lat, 3);
    transact(1'b0, 8'h00, 8'hFF, rd, er, lat, acc, bad);
    chk("wr_m0_acc", acc, 0);
    transact(1'b1, 8'hFF, 8'h00, rd, er, lat, acc, bad);
    chk("rd_after_m0", int'(rd), 'hAC);

    // Read immediately followed by a write, req_valid held high.
    v0 = viol_tot;
    @(negedge clock);
    dp.req_valid = 1'b1; dp.req_rw = 1'b1;
    dp.req_mask = 8'hFF; dp.rsp_ready = 1'b1;
    @(posedge clock); #1;
    dp.req_rw = 1'b0; dp.req_mask = 8'hF0; dp.req_wdata = 8'h5A;
    n = 0;
    while (!dp.rsp_valid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("b2b_rd_lat", n, 3);
    chk("b2b_rd_rdata", int'(dp.rsp_rdata), 'hAC);
    @(posedge clock); #1;
    chk("b2b_idle", int'(dp.req_ready), 1);
    @(posedge clock); #1;
    dp.req_valid = 1'b0;
    chk("b2b_wr_accept", int'(dp.req_ready), 0);
    n = 0;
    while (!dp.rsp_valid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("b2b_wr_lat", n, WR_LAT);
    @(posedge clock); #1;
    dp.rsp_ready = 1'b0;
    chk("b2b_no_drive_rw1", viol_tot - v0, 0);

    // Response stall with a second request waiting.
    @(negedge clock);
    dp.req_valid = 1'b1; dp.req_rw = 1'b1; dp.req_mask = 8'hFF;
    @(posedge clock); #1;
    dp.req_mask = 8'h0F;
    n = 0;
    while (!dp.rsp_valid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("stall_rdata", int'(dp.rsp_rdata), 'h5C);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("stall_hold",
          int'({dp.rsp_valid, dp.req_ready, dp.rsp_rdata}),
          int'({1'b1, 1'b0, 8'h5C}));
    end
    @(negedge clock);
    dp.rsp_ready = 1'b1;
    @(posedge clock); #1;
    dp.rsp_ready = 1'b0;
    chk("stall_after_hs",
        int'({dp.rsp_valid, dp.req_ready}), int'(2'b01));
    @(posedge clock); #1;
    dp.req_valid = 1'b0;
    chk("stall_2nd_accept", int'(dp.req_ready), 0);
    n = 0;
    while (!dp.rsp_valid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("stall_2nd_rdata", int'(dp.rsp_rdata), 'h0C);
    @(negedge clock);
    dp.rsp_ready = 1'b1;
    @(posedge clock); #1;
    dp.rsp_ready = 1'b0;

    // WAIT_CYC=3 instance.
    a3 = add3_tot;
    @(negedge clock);
    dp3.req_valid = 1'b1; dp3.req_rw = 1'b1; dp3.req_mask = 8'hFF;
    @(posedge clock); #1;
    dp3.req_valid = 1'b0;
    n = 0;
    while (!dp3.rsp_valid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("w3_lat", n, 5);
    chk("w3_rdata", int'(dp3.rsp_rdata), 'h5A);
    chk("w3_acc", add3_tot - a3, 3);
    @(negedge clock);
    dp3.rsp_ready = 1'b1;
    @(posedge clock); #1;
    dp3.rsp_ready = 1'b0;
    chk("w3_done", int'(dp3.req_ready), 1);

`ifdef ACC_WR_VERIFY_EN
    stuck_b2 = 1'b1;
    transact(1'b0, 8'hFF, 8'hFF, rd, er, lat, acc, bad);
    chk("vfy_stuck_rdata", int'(rd), 'hFB);
    chk("vfy_stuck_err", int'(er), 1);
    stuck_b2 = 1'b0;
    transact(1'b0, 8'hFF, 8'hFF, rd, er, lat, acc, bad);
    chk("vfy_ok_rdata", int'(rd), 'hFF);
    chk("vfy_ok_err", int'(er), 0);
    chk("vfy_ok_lat", lat, 7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
